mul_hilo_sequencer: RTL

- Multicycle control stage wrapped around the combinational 32x32 Booth bit-pair multiplier in the ALU datapath.
- Registers the operands and holds them stable on the multiplier inputs for a fixed settle window, because the ripple-adder tree is a multicycle path.
- Captures the 64-bit product into the architectural HI/LO registers and handshakes completion back to the control unit.
- Also services direct HI/LO writes (mthi/mtlo).

---
 rtl/mul_hilo_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mul_hilo_sequencer.sv
// Multicycle operand/capture sequencer around the combinational 32x32 Booth multiplier, owning HI/LO.
// Latency: start at edge E0 -> done (HI/LO valid) in the cycle after edge E0+SETTLE_CYCLES+1.
// Backpressure: none queued; start and direct HI/LO writes are ignored while busy.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, op_a, op_b     multiply request and operands (accepted only when idle)
//   mul_a, mul_b          registered operands held stable on the multiplier inputs
//   mul_product           64-bit product from the multiplier, sampled once at capture
//   hi_we, lo_we, wr_data direct HI/LO writes (mthi/mtlo), honoured only when not busy
//   busy, done            busy during settle/capture; done pulses one cycle after capture
//   hi, lo                architectural HI/LO registers
//
// Optional build macro MUL_UNSIGNED_EN adds input unsigned_op, which selects an
// unsigned result by correcting the upper product word at capture.
module mul_hilo_sequencer #(
  parameter int SETTLE_CYCLES = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef MUL_UNSIGNED_EN
  input  logic        unsigned_op,
`endif
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES edges.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        start_accept;
  logic        capture_en;
  logic [31:0] hi_cap;

  assign start_accept = (state == IDLE) && start;
  assign capture_en   = (state == CAPTURE);
  assign busy         = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nxt = CAPTURE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MUL_UNSIGNED_EN
  logic unsigned_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            unsigned_q <= 1'b0;
    else if (start_accept) unsigned_q <= unsigned_op;
  end

  // Signed-to-unsigned fixup: each operand with its sign bit set was interpreted
  // as (x - 2^32), so add back the other operand into the upper word.
  always_comb begin
    hi_cap = mul_product[63:32];
    if (unsigned_q) begin
      hi_cap = mul_product[63:32]
             + (mul_a[31] ? mul_b : 32'd0)
             + (mul_b[31] ? mul_a : 32'd0);
    end
  end
`else
  assign hi_cap = mul_product[63:32];
`endif

  // Operand, result and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= 32'd0;
      mul_b <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= capture_en;
      if (start_accept) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      // Capture and direct writes are mutually exclusive: direct writes need !busy.
      if (capture_en) begin
        hi <= hi_cap;
        lo <= mul_product[31:0];
      end else if (!busy) begin
        if (hi_we) hi <= wr_data;
        if (lo_we) lo <= wr_data;
      end
    end
  end

endmodule
